// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pipe_pkg
// Description : Shared pipeline definitions: register-file geometry defaults,
//               register index type and a constant-evaluable clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pipe_pkg;

    localparam int c_REG_AW   = 4;
    localparam int c_NUM_REGS = 16;

    typedef logic [c_REG_AW-1:0] reg_idx_t;

    // Ceiling log2, usable in parameter/localparam elaboration.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_hazard_unit_if
// Description : Pipeline-side bundle for the scoreboard hazard unit. The
//               master is the pipeline (ID/WB stages), the slave is the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface scoreboard_hazard_unit_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 32
);
    logic              forward_en;
    logic              mem_ready;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_src1_used;
    logic              id_src2_used;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic [REG_AW-1:0] id_dest;
    logic              wb_en;
    logic [REG_AW-1:0] wb_dest;
    logic              perf_clr;
    logic              hazard;
    logic              issue;
    logic              pending_any;
    logic [CNT_W-1:0]  stall_cycles;
    logic              sb_err;

    modport master (
        output forward_en, mem_ready, flush, id_valid,
        output id_src1, id_src2, id_src1_used, id_src2_used,
        output id_wb_en, id_mem_r_en, id_dest, wb_en, wb_dest, perf_clr,
        input  hazard, issue, pending_any, stall_cycles, sb_err
    );

    modport slave (
        input  forward_en, mem_ready, flush, id_valid,
        input  id_src1, id_src2, id_src1_used, id_src2_used,
        input  id_wb_en, id_mem_r_en, id_dest, wb_en, wb_dest, perf_clr,
        output hazard, issue, pending_any, stall_cycles, sb_err
    );

endinterface
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Per-register pending-write counter. Simultaneous inc/dec
//               cancel; a lone dec at zero holds zero and flags underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int PW      = 2,
    parameter int MAX_VAL = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_inc,
    input  wire logic          i_dec,
    output logic [PW-1:0]      o_cnt,
    output logic               o_underflow
);

    localparam logic [PW-1:0] c_MAX = PW'(MAX_VAL);

    logic [PW-1:0] r_cnt;

    // Up/down count; saturate at the ceiling defensively (the overflow stall
    // normally prevents an increment there) and never wrap below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt != c_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_cnt       = r_cnt;
    assign o_underflow = i_dec & ~i_inc & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_hazard_unit
// Description : Scoreboard-based RAW/structural hazard detector. Pending
//               writes are counted per register so detection does not depend
//               on pipeline depth; an EXE shadow slot supports load-use
//               detection when forwarding is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_hazard_unit
    import arm_pipe_pkg::*;
#(
    parameter int NUM_REGS     = c_NUM_REGS,
    parameter int REG_AW       = c_REG_AW,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    scoreboard_hazard_unit_if.slave  io_bus
);

    localparam int              c_PW  = clog2(MAX_INFLIGHT + 1);
    localparam logic [c_PW-1:0] c_MAX = c_PW'(MAX_INFLIGHT);

    logic                w_freeze;
    logic                w_retire;
    logic                w_issue;
    logic                w_hazard;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_uflow;
    logic [c_PW-1:0]     w_pend [NUM_REGS];

    logic                w_nz_src1;
    logic                w_nz_src2;
    logic                w_full_dest;
    logic                w_any;
    logic                w_exe_in_range;
    logic                w_hit1;
    logic                w_hit2;

    logic                r_exe_vld;
    logic [REG_AW-1:0]   r_exe_dest;
    logic                r_exe_load;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                r_sb_err;

    assign w_freeze = ~io_bus.mem_ready;
    assign w_retire = io_bus.wb_en & ~w_freeze;

    // One pending counter per tracked register; indices at or above NUM_REGS
    // match no counter and are therefore ignored entirely.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_inc[g] = w_issue & io_bus.id_wb_en & (io_bus.id_dest == REG_AW'(g));
        assign w_dec[g] = w_retire & (io_bus.wb_dest == REG_AW'(g));

        sb_counter #(
            .PW      (c_PW),
            .MAX_VAL (MAX_INFLIGHT)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[g]),
            .i_dec       (w_dec[g]),
            .o_cnt       (w_pend[g]),
            .o_underflow (w_uflow[g])
        );
    end

    // Scan the counters for the source/destination lookups; out-of-range
    // indices never match and read as "not pending".
    always_comb begin
        w_nz_src1      = 1'b0;
        w_nz_src2      = 1'b0;
        w_full_dest    = 1'b0;
        w_any          = 1'b0;
        w_exe_in_range = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((io_bus.id_src1 == REG_AW'(r)) && (w_pend[r] != '0)) begin
                w_nz_src1 = 1'b1;
            end
            if ((io_bus.id_src2 == REG_AW'(r)) && (w_pend[r] != '0)) begin
                w_nz_src2 = 1'b1;
            end
            if ((io_bus.id_dest == REG_AW'(r)) && (w_pend[r] == c_MAX)) begin
                w_full_dest = 1'b1;
            end
            if (w_pend[r] != '0) begin
                w_any = 1'b1;
            end
            if (r_exe_dest == REG_AW'(r)) begin
                w_exe_in_range = 1'b1;
            end
        end
    end

    // With forwarding only a load in EXE cannot be bypassed in time;
    // without it any outstanding write to a source blocks issue.
    assign w_hit1 = io_bus.id_src1_used &
                    (io_bus.forward_en ?
                        (r_exe_vld & r_exe_load & w_exe_in_range & (r_exe_dest == io_bus.id_src1)) :
                        w_nz_src1);
    assign w_hit2 = io_bus.id_src2_used &
                    (io_bus.forward_en ?
                        (r_exe_vld & r_exe_load & w_exe_in_range & (r_exe_dest == io_bus.id_src2)) :
                        w_nz_src2);

    assign w_hazard = io_bus.id_valid & (w_hit1 | w_hit2 | (io_bus.id_wb_en & w_full_dest));
    assign w_issue  = io_bus.id_valid & ~w_hazard & ~io_bus.flush & ~w_freeze;

    // EXE shadow slot: frozen with the pipeline, otherwise tracks what issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_vld  <= 1'b0;
            r_exe_dest <= '0;
            r_exe_load <= 1'b0;
        end else if (!w_freeze) begin
            if (w_issue) begin
                r_exe_vld  <= io_bus.id_wb_en;
                r_exe_dest <= io_bus.id_dest;
                r_exe_load <= io_bus.id_mem_r_en;
            end else begin
                r_exe_vld  <= 1'b0;
                r_exe_dest <= '0;
                r_exe_load <= 1'b0;
            end
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (io_bus.perf_clr) begin
            r_stall_cycles <= '0;
        end else if (io_bus.id_valid && w_hazard && !io_bus.flush && !w_freeze
                     && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // Sticky error: a retire arrived for a register with nothing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_err <= 1'b0;
        end else if (|w_uflow) begin
            r_sb_err <= 1'b1;
        end
    end

    assign io_bus.hazard       = w_hazard;
    assign io_bus.issue        = w_issue;
    assign io_bus.pending_any  = w_any;
    assign io_bus.stall_cycles = r_stall_cycles;
    assign io_bus.sb_err       = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_scoreboard_hazard_unit
// Description : Table-driven self-checking bench for scoreboard_hazard_unit
//               (NUM_REGS=12 to exercise ignored indices, CNT_W=4 to reach
//               saturation quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_hazard_unit;

    typedef struct {
        logic       fwd, mrdy, flush, vld;
        logic [3:0] s1;
        logic       s1u;
        logic [3:0] s2;
        logic       s2u;
        logic       wben, ld;
        logic [3:0] dest;
        logic       wb;
        logic [3:0] wbd;
        logic       pclr;
        logic       hz, iss, pany;
        logic [3:0] st;
        logic       err;
    } vec_t;

    typedef struct {
        int         idx;
        logic       hz, iss, pany;
        logic [3:0] st;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t tab[$];
    exp_t exp_q[$];

    scoreboard_hazard_unit_if #(.REG_AW(4), .CNT_W(4)) bus ();

    scoreboard_hazard_unit #(
        .NUM_REGS     (12),
        .REG_AW       (4),
        .MAX_INFLIGHT (3),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(int fwd, int mrdy, int fl, int vld,
                               int s1, int s1u, int s2, int s2u,
                               int wben, int ld, int dest, int wb, int wbd, int pclr,
                               int hz, int iss, int pany, int st, int err);
        vec_t r;
        r.fwd  = 1'(fwd);  r.mrdy = 1'(mrdy); r.flush = 1'(fl);  r.vld = 1'(vld);
        r.s1   = 4'(s1);   r.s1u  = 1'(s1u);  r.s2    = 4'(s2);  r.s2u = 1'(s2u);
        r.wben = 1'(wben); r.ld   = 1'(ld);   r.dest  = 4'(dest);
        r.wb   = 1'(wb);   r.wbd  = 4'(wbd);  r.pclr  = 1'(pclr);
        r.hz   = 1'(hz);   r.iss  = 1'(iss);  r.pany  = 1'(pany);
        r.st   = 4'(st);   r.err  = 1'(err);
        return r;
    endfunction

    task automatic drive(input vec_t t);
        bus.forward_en   = t.fwd;
        bus.mem_ready    = t.mrdy;
        bus.flush        = t.flush;
        bus.id_valid     = t.vld;
        bus.id_src1      = t.s1;
        bus.id_src1_used = t.s1u;
        bus.id_src2      = t.s2;
        bus.id_src2_used = t.s2u;
        bus.id_wb_en     = t.wben;
        bus.id_mem_r_en  = t.ld;
        bus.id_dest      = t.dest;
        bus.wb_en        = t.wb;
        bus.wb_dest      = t.wbd;
        bus.perf_clr     = t.pclr;
    endtask

    task automatic push_exp(input int idx, input vec_t t);
        exp_t e;
        e.idx = idx; e.hz = t.hz; e.iss = t.iss; e.pany = t.pany; e.st = t.st; e.err = t.err;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT's current outputs.
    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: output sampled with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            chk("hazard",       e.idx, int'(bus.hazard),       int'(e.hz));
            chk("issue",        e.idx, int'(bus.issue),        int'(e.iss));
            chk("pending_any",  e.idx, int'(bus.pending_any),  int'(e.pany));
            chk("stall_cycles", e.idx, int'(bus.stall_cycles), int'(e.st));
            chk("sb_err",       e.idx, int'(bus.sb_err),       int'(e.err));
        end
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        drive(t);
        push_exp(idx, t);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t t;
        int   st;
        n_checks = 0;
        n_errors = 0;
        idle = v(0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);

        //            fwd mr fl vld s1 u s2 u  wbe ld dst wb wbd clr  hz is pa st er
        // Full interlock: producer r3, consumer stalls until WB retires r3.
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,0,0));
        tab.push_back(v(0,1,0,1, 1,1,0,0, 1,0,3,  0,0,0,  0,1,0,0,0));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 1,0,4,  0,0,0,  1,0,1,0,0));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 1,0,4,  0,0,0,  1,0,1,1,0));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 1,0,4,  1,3,0,  1,0,1,2,0));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 1,0,4,  0,0,0,  0,1,0,3,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  1,4,0,  0,0,1,3,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,3,0));
        // Forwarding: load-use stalls one cycle, ALU producer does not.
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,1,5,  0,0,0,  0,1,0,3,0));
        tab.push_back(v(1,1,0,1, 0,0,5,1, 0,0,0,  0,0,0,  1,0,1,3,0));
        tab.push_back(v(1,1,0,1, 0,0,5,1, 0,0,0,  0,0,0,  0,1,1,4,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,6,  0,0,0,  0,1,1,4,0));
        tab.push_back(v(1,1,0,1, 6,1,0,0, 0,0,0,  0,0,0,  0,1,1,4,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,5,0,  0,0,1,4,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,6,0,  0,0,1,4,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,4,0));
        // Structural limit on r2: fourth write stalls; issue+retire cancels.
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  0,1,0,4,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  0,1,1,4,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  0,1,1,4,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  1,0,1,4,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  1,0,1,5,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  1,2,0,  1,0,1,6,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  1,2,0,  0,1,1,7,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  0,1,1,7,0));
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,0,2,  0,0,0,  1,0,1,7,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,2,0,  0,0,1,8,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,2,0,  0,0,1,8,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,2,0,  0,0,1,8,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,8,0));
        // Memory wait: load r5 in EXE, five frozen cycles, WB retire masked.
        tab.push_back(v(1,1,0,1, 0,0,0,0, 1,1,5,  0,0,0,  0,1,0,8,0));
        tab.push_back(v(1,0,0,1, 5,1,0,0, 0,0,0,  0,0,0,  1,0,1,8,0));
        tab.push_back(v(1,0,0,1, 5,1,0,0, 0,0,0,  0,0,0,  1,0,1,8,0));
        tab.push_back(v(1,0,0,1, 5,1,0,0, 0,0,0,  1,5,0,  1,0,1,8,0));
        tab.push_back(v(1,0,0,1, 5,1,0,0, 0,0,0,  0,0,0,  1,0,1,8,0));
        tab.push_back(v(1,0,0,1, 5,1,0,0, 0,0,0,  0,0,0,  1,0,1,8,0));
        tab.push_back(v(1,1,0,1, 5,1,0,0, 0,0,0,  0,0,0,  1,0,1,8,0));
        tab.push_back(v(1,1,0,1, 5,1,0,0, 0,0,0,  0,0,0,  0,1,1,9,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  1,5,0,  0,0,1,9,0));
        tab.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,9,0));
        // Flush squashes the write to r7 and a stalled consumer is not counted.
        tab.push_back(v(0,1,1,1, 0,0,0,0, 1,0,7,  0,0,0,  0,0,0,9,0));
        tab.push_back(v(0,1,0,1, 7,1,0,0, 0,0,0,  0,0,0,  0,1,0,9,0));
        tab.push_back(v(0,1,0,1, 0,0,0,0, 1,0,8,  0,0,0,  0,1,0,9,0));
        tab.push_back(v(0,1,1,1, 8,1,0,0, 0,0,0,  0,0,0,  1,0,1,9,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  1,8,0,  0,0,1,9,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,9,0));
        // Indices 13/14 are beyond NUM_REGS: never pending, no error on retire.
        tab.push_back(v(0,1,0,1, 0,0,0,0, 1,0,13, 0,0,0,  0,1,0,9,0));
        tab.push_back(v(0,1,0,1, 13,1,13,1, 0,0,0, 0,0,0, 0,1,0,9,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  1,14,0, 0,0,0,9,0));
        // Retire r9 with nothing pending: sticky error.
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  1,9,0,  0,0,0,9,0));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,9,1));
        tab.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0,  0,0,0,  0,0,0,9,1));
        // Saturation of the 4-bit stall counter, then clear.
        tab.push_back(v(0,1,0,1, 0,0,0,0, 1,0,3,  0,0,0,  0,1,0,9,1));
        for (int k = 0; k < 9; k++) begin
            st = (9 + k > 15) ? 15 : 9 + k;
            tab.push_back(v(0,1,0,1, 3,1,0,0, 0,0,0, 0,0,0, 1,0,1,st,1));
        end
        tab.push_back(v(0,1,0,1, 3,1,0,0, 0,0,0,  0,0,1,  1,0,1,15,1));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 0,0,0,  0,0,0,  1,0,1,0,1));
        tab.push_back(v(0,1,0,1, 3,1,0,0, 0,0,0,  0,0,0,  1,0,1,1,1));

        rst = 1'b1;
        drive(idle);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            run_vec(i, tab[i]);
        end

        // Reset in the middle of a stall: tracking, counter and error all clear.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = v(0,1,0,1, 3,1,0,0, 0,0,0, 0,0,0, 0,1,0,0,0);
        run_vec(1000, t);
        t = idle;
        run_vec(1001, t);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
